// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction memory for the core's fetch port, filled at boot
// from a byte stream (MSB first). The core is held in reset (cpu_rst_o high)
// until a complete image has been written.
//
// Optional build macro BOOT_CHECKSUM_EN: after load_done_i the next four bytes
// carry a 32-bit wrap-around sum of the image. A mismatch parks the block in an
// error state (err_o=1, core held in reset) until load_start_i or rst.
//
// Loader handshake: a byte moves on a rising clk edge when byte_valid_i and
// byte_ready_o are both high. byte_ready_o depends only on registered state.
// byte_valid_i may be asserted without waiting for byte_ready_o, and a byte
// offered while byte_ready_o is low is simply not taken.
//
// FSM state is visible at the ports: loading_o=1 means S_LOAD, cpu_rst_o=0
// means S_RUN, err_o=1 means S_ERR. With cpu_rst_o=1, loading_o=0 and err_o=0
// after the first clock, the block is in S_CHK.
module inst_rom_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  input  logic              load_start_i,
  input  logic              load_done_i,
  output logic              cpu_rst_o,
  output logic              loading_o,
  output logic [ADDR_W:0]   words_o,
  output logic              err_o
);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_CHK, S_ERR} state_t;
`else
  typedef enum logic {S_LOAD, S_RUN} state_t;
`endif

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic              active_q;       // low only until the first clock after reset
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  logic              byte_xfer;
  logic              full;
  logic [31:0]       shifted;
  logic [1:0]        cnt_after;
  logic [31:0]       asm_after;
  logic              word_done;
  logic              wr_req;
  logic [31:0]       wr_word;

  logic [ADDR_W-1:0] rd_idx;
  logic              rd_hit;
  logic              unused_addr_bits;

  // Status outputs decoded from the registered state.
  always_comb begin
    byte_ready_o = 1'b0;
    loading_o    = 1'b0;
    cpu_rst_o    = (state_q != S_RUN);
    err_o        = 1'b0;
    if (active_q && state_q == S_LOAD) begin
      byte_ready_o = 1'b1;
      loading_o    = 1'b1;
    end
`ifdef BOOT_CHECKSUM_EN
    if (active_q && state_q == S_CHK) byte_ready_o = 1'b1;
    err_o = (state_q == S_ERR);
`endif
  end

  assign words_o   = wptr_q;
  assign byte_xfer = byte_valid_i && byte_ready_o;
  assign full      = (wptr_q == FULL_CNT);
  assign shifted   = {asm_q[23:0], byte_data_i};

  // Next-state, byte assembly and memory write request.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    wptr_d    = wptr_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    mem_we    = 1'b0;
    mem_waddr = wptr_q[ADDR_W-1:0];
    mem_wdata = 32'h0;
    cnt_after = bcnt_q;
    asm_after = asm_q;
    word_done = 1'b0;
    wr_req    = 1'b0;
    wr_word   = 32'h0;

    case (state_q)
      S_LOAD: begin
        if (active_q) begin
          if (load_start_i) begin
            // Restart wins over a same-cycle byte or done.
            bcnt_d = 2'd0;
            asm_d  = 32'h0;
            wptr_d = '0;
`ifdef BOOT_CHECKSUM_EN
            csum_d = 32'h0;
`endif
          end else begin
            // Fold in a same-cycle byte before considering load_done_i.
            if (byte_xfer) begin
              asm_after = shifted;
              if (bcnt_q == 2'd3) begin
                word_done = 1'b1;
                cnt_after = 2'd0;
              end else begin
                cnt_after = bcnt_q + 2'd1;
              end
            end

            if (word_done) begin
              wr_req  = 1'b1;
              wr_word = asm_after;
            end else if (load_done_i && cnt_after != 2'd0) begin
              // Partial trailing word: bytes received so far go high, rest zero.
              wr_req = 1'b1;
              case (cnt_after)
                2'd1:    wr_word = {asm_after[7:0],  24'h0};
                2'd2:    wr_word = {asm_after[15:0], 16'h0};
                default: wr_word = {asm_after[23:0], 8'h0};
              endcase
            end

            // Once the memory is full, words are dropped and the count holds.
            if (wr_req && !full) begin
              mem_we    = 1'b1;
              mem_wdata = wr_word;
              wptr_d    = wptr_q + ONE_CNT;
`ifdef BOOT_CHECKSUM_EN
              csum_d    = csum_q + wr_word;
`endif
            end

            bcnt_d = cnt_after;
            asm_d  = asm_after;

            if (load_done_i) begin
              bcnt_d = 2'd0;
              asm_d  = 32'h0;
`ifdef BOOT_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_RUN;
`endif
            end
          end
        end
      end

      S_RUN: begin
        if (load_start_i) begin
          state_d = S_LOAD;
          bcnt_d  = 2'd0;
          asm_d   = 32'h0;
          wptr_d  = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_d  = 32'h0;
`endif
        end
      end

`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        // load_done_i is ignored here; only the four checksum bytes matter.
        if (load_start_i) begin
          state_d = S_LOAD;
          bcnt_d  = 2'd0;
          asm_d   = 32'h0;
          wptr_d  = '0;
          csum_d  = 32'h0;
        end else if (byte_xfer) begin
          asm_d = shifted;
          if (bcnt_q == 2'd3) begin
            bcnt_d  = 2'd0;
            state_d = (shifted == csum_q) ? S_RUN : S_ERR;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end

      S_ERR: begin
        if (load_start_i) begin
          state_d = S_LOAD;
          bcnt_d  = 2'd0;
          asm_d   = 32'h0;
          wptr_d  = '0;
          csum_d  = 32'h0;
        end
      end
`endif

      default: state_d = S_LOAD;
    endcase
  end

  // Control registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      active_q <= 1'b0;
      bcnt_q   <= 2'd0;
      asm_q    <= 32'h0;
      wptr_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q   <= 32'h0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      wptr_q   <= wptr_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Instruction memory write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_idx           = rom_addr_i[ADDR_W+1:2];
  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

  // Combinational fetch; anything outside the loaded image reads as zero.
  always_comb begin
    rd_hit     = rom_ce_i && (state_q == S_RUN) && ({1'b0, rd_idx} < wptr_q);
    rom_data_o = 32'h0;
    if (rd_hit) rom_data_o = mem[rd_idx];
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader (small DEPTH so the full-memory case is short).
module tb_inst_rom_loader;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              rom_ce;
  logic [31:0]       rom_addr;
  logic [31:0]       rom_data;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              load_start;
  logic              load_done;
  logic              cpu_rst;
  logic              loading;
  logic [ADDR_W:0]   words;
  logic              err;

  int checks;
  int errors;

  inst_rom_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce),
    .rom_addr_i   (rom_addr),
    .rom_data_o   (rom_data),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .load_start_i (load_start),
    .load_done_i  (load_done),
    .cpu_rst_o    (cpu_rst),
    .loading_o    (loading),
    .words_o      (words),
    .err_o        (err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input logic done);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    load_done  = done;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   1'b0);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    load_done = 1'b1;
    @(posedge clk);
    #1;
    load_done = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got=%b exp=0", byte_ready); end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading got=%b exp=0", loading); end
    checks++; if (words !== '0) begin errors++; $display("FAIL reset_words got=%0d exp=0", words); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    rom_ce = 1'b1; rom_addr = 32'h0; #1;
    checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL reset_rom_data got=%h exp=0", rom_data); end
    rom_ce = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early got=%b exp=0", byte_ready); end
    @(posedge clk); #1;
    checks++; if (byte_ready !== 1'b1 || loading !== 1'b1) begin errors++; $display("FAIL release_ready got=%b%b exp=11", byte_ready, loading); end
  endtask

  task automatic test_basic_load();
    send_word(32'h34010011);
    checks++; if (words !== 5'd1) begin errors++; $display("FAIL basic_words1 got=%0d exp=1", words); end
    send_word(32'h34020022);
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL basic_rst_before_done got=%b exp=1", cpu_rst); end
    pulse_done();
    checks++; if (cpu_rst !== 1'b0 || loading !== 1'b0) begin errors++; $display("FAIL basic_run got=%b%b exp=00", cpu_rst, loading); end
    checks++; if (words !== 5'd2) begin errors++; $display("FAIL basic_words got=%0d exp=2", words); end
    rom_ce = 1'b1;
    rom_addr = 32'h0; #1;
    checks++; if (rom_data !== 32'h34010011) begin errors++; $display("FAIL basic_fetch0 got=%h exp=34010011", rom_data); end
    rom_addr = 32'h4; #1;
    checks++; if (rom_data !== 32'h34020022) begin errors++; $display("FAIL basic_fetch4 got=%h exp=34020022", rom_data); end
    rom_addr = 32'h8; #1;
    checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL basic_fetch8 got=%h exp=0", rom_data); end
    rom_ce = 1'b0; rom_addr = 32'h0; #1;
    checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL basic_ce_off got=%h exp=0", rom_data); end
  endtask

  task automatic test_restart_partial();
    pulse_start();
    checks++; if (cpu_rst !== 1'b1 || loading !== 1'b1) begin errors++; $display("FAIL restart_state got=%b%b exp=11", cpu_rst, loading); end
    checks++; if (words !== '0) begin errors++; $display("FAIL restart_words got=%0d exp=0", words); end
    rom_ce = 1'b1; rom_addr = 32'h0; #1;
    checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL restart_fetch got=%h exp=0", rom_data); end
    rom_ce = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b1);
    checks++; if (words !== 5'd2) begin errors++; $display("FAIL partial_words got=%0d exp=2", words); end
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL partial_run got=%b exp=0", cpu_rst); end
    rom_ce = 1'b1;
    rom_addr = 32'h4; #1;
    checks++; if (rom_data !== 32'hEE000000) begin errors++; $display("FAIL partial_fetch4 got=%h exp=ee000000", rom_data); end
    rom_addr = 32'h7; #1;
    checks++; if (rom_data !== 32'hEE000000) begin errors++; $display("FAIL partial_lowbits got=%h exp=ee000000", rom_data); end
    rom_addr = 32'h0; #1;
    checks++; if (rom_data !== 32'hAABBCCDD) begin errors++; $display("FAIL partial_fetch0 got=%h exp=aabbccdd", rom_data); end
    rom_ce = 1'b0;
  endtask

  task automatic test_reset_abort();
    pulse_start();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    #2; rst = 1'b0; #1;
    checks++; if (cpu_rst !== 1'b1 || byte_ready !== 1'b0 || loading !== 1'b0) begin errors++; $display("FAIL abort_async got=%b%b%b exp=100", cpu_rst, byte_ready, loading); end
    checks++; if (words !== '0) begin errors++; $display("FAIL abort_words got=%0d exp=0", words); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send_word(32'h11223344);
    pulse_done();
    checks++; if (words !== 5'd1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL abort_reload got=%0d/%b exp=1/0", words, cpu_rst); end
    rom_ce = 1'b1; rom_addr = 32'h0; #1;
    checks++; if (rom_data !== 32'h11223344) begin errors++; $display("FAIL abort_fetch0 got=%h exp=11223344", rom_data); end
    rom_addr = 32'h4; #1;
    checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL abort_fetch4 got=%h exp=0", rom_data); end
    rom_ce = 1'b0;
  endtask

  task automatic test_full();
    pulse_start();
    for (int i = 0; i <= DEPTH; i++) send_word(32'hC0DE0000 + 32'(i));
    checks++; if (words !== 5'd16 || byte_ready !== 1'b1) begin errors++; $display("FAIL full_sat got=%0d/%b exp=16/1", words, byte_ready); end
    pulse_done();
    checks++; if (words !== 5'd16 || cpu_rst !== 1'b0) begin errors++; $display("FAIL full_done got=%0d/%b exp=16/0", words, cpu_rst); end
    rom_ce = 1'b1; rom_addr = 32'(DEPTH - 1) * 32'd4; #1;
    checks++; if (rom_data !== 32'hC0DE000F) begin errors++; $display("FAIL full_last got=%h exp=c0de000f", rom_data); end
    rom_addr = 32'h0; #1;
    checks++; if (rom_data !== 32'hC0DE0000) begin errors++; $display("FAIL full_first got=%h exp=c0de0000", rom_data); end
    rom_ce = 1'b0;
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_word(32'h00000001);
    send_word(32'hFFFFFFFF);
    pulse_done();
    checks++; if (cpu_rst !== 1'b1 || loading !== 1'b0 || byte_ready !== 1'b1) begin errors++; $display("FAIL chk_wait got=%b%b%b exp=101", cpu_rst, loading, byte_ready); end
    send_word(32'h00000000);
    checks++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL chk_match got=%b%b exp=00", cpu_rst, err); end
    rom_ce = 1'b1; rom_addr = 32'h4; #1;
    checks++; if (rom_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL chk_fetch got=%h exp=ffffffff", rom_data); end
    rom_ce = 1'b0;
    pulse_start();
    send_word(32'h00000001);
    send_word(32'hFFFFFFFF);
    pulse_done();
    send_word(32'h00000001);
    checks++; if (err !== 1'b1 || cpu_rst !== 1'b1) begin errors++; $display("FAIL chk_mismatch got=%b%b exp=11", err, cpu_rst); end
    pulse_done();
    repeat (3) @(posedge clk); #1;
    checks++; if (err !== 1'b1 || cpu_rst !== 1'b1) begin errors++; $display("FAIL chk_err_hold got=%b%b exp=11", err, cpu_rst); end
    pulse_start();
    checks++; if (err !== 1'b0 || loading !== 1'b1) begin errors++; $display("FAIL chk_err_clear got=%b%b exp=01", err, loading); end
  endtask
`endif

  // Test sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    rom_ce = 1'b0;
    rom_addr = 32'h0;
    byte_valid = 1'b0;
    byte_data = 8'h0;
    load_start = 1'b0;
    load_done = 1'b0;
    test_reset();
    test_basic_load();
    test_restart_partial();
    test_reset_abort();
    test_full();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
